// File: rtl/smooth_filter_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : smooth_filter_stream_if
// Description : Valid/ready stream bundle for smooth_filter_stream. It groups
//               the sample input stream (in_*) and the filtered output
//               stream (out_*).
//               slave  : view of the filter block
//               master : view of the producer/consumer driving the block
// Ports       : in_valid, in_data, in_ready   -- sample input stream
//               out_valid, out_data, out_ready -- filtered output stream
// Revision    : 1.0 - initial release
// ============================================================================
interface smooth_filter_stream_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/smooth_filter_stream.sv
`default_nettype none
// ============================================================================
// Module      : smooth_filter_stream
// Description : Buffers a runtime-length block of samples, then streams out
//               the moving average over a 2**FILT_LOG2 sample window.
//               Optional macro SMOOTH_ROUND_EN selects round-half-up
//               averaging; without it the average is truncated.
// Ports       : clk      - clock, posedge
//               rst      - asynchronous reset, active low
//               cfg_len  - block length, sampled when start is accepted
//               start    - begin a block (IDLE only)
//               abort    - cancel the current block
//               s_if     - input/output sample streams (slave modport)
//               busy     - block not in IDLE
//               done     - one-cycle pulse after the last output handshake
//               err      - one-cycle pulse when start is rejected
// Revision    : 1.0 - initial release
// ============================================================================
module smooth_filter_stream #(
    parameter int DATA_W    = 8,
    parameter int MAX_LEN   = 100,
    parameter int FILT_LOG2 = 3
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  wire logic                         start,
    input  wire logic                         abort,
    smooth_filter_stream_if.slave             s_if,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);
    localparam int LEN_W  = $clog2(MAX_LEN+1);
    localparam int SUM_W  = DATA_W + FILT_LOG2;
    localparam int WIN    = 2**FILT_LOG2;
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_PRIME = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;      // wr_ptr in LOAD, prime index, k in SEND
    logic [LEN_W-1:0]   len_q, len_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               wr_en;
    logic               len_ok;
    logic [DATA_W-1:0]  buf_q [MAX_LEN];
    logic [DATA_W-1:0]  rd_old;            // buf[k]
    logic [DATA_W-1:0]  rd_new;            // buf[k+WIN]

    assign len_ok = (cfg_len >= LEN_W'(WIN)) && (cfg_len <= LEN_W'(MAX_LEN));

    // cnt_q+WIN only exceeds the buffer on the final output, where the
    // read value is not used.
    assign rd_old = buf_q[cnt_q[ADDR_W-1:0]];
    assign rd_new = buf_q[ADDR_W'(cnt_q + LEN_W'(WIN))];

    // Sample buffer: no reset, combinational read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[cnt_q[ADDR_W-1:0]] <= s_if.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sum_d   = sum_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d   = cfg_len;
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (s_if.in_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_PRIME;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            S_PRIME: begin
                sum_d = sum_q + SUM_W'(rd_old);
                if (cnt_q == LEN_W'(WIN-1)) begin
                    cnt_d   = '0;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_SEND: begin
                if (s_if.out_ready) begin
                    if (cnt_q == len_q - LEN_W'(WIN)) begin
                        cnt_d   = '0;
                        sum_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Slide the window: modular arithmetic keeps the
                        // non-negative result exact in SUM_W bits.
                        sum_d = sum_q + SUM_W'(rd_new) - SUM_W'(rd_old);
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over any handshake in the same cycle.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sum_d   = '0;
            done_d  = 1'b0;
            wr_en   = 1'b0;
        end
    end

    // Outputs decode from registered state so reset clears them at once.
    assign s_if.in_ready  = (state_q == S_LOAD);
    assign s_if.out_valid = (state_q == S_SEND);
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign err            = err_q;

`ifdef SMOOTH_ROUND_EN
    localparam logic [SUM_W:0] HALF = (SUM_W+1)'(1) << (FILT_LOG2-1);
    logic [SUM_W:0] sum_rnd;
    assign sum_rnd = {1'b0, sum_q} + HALF;
    assign s_if.out_data = (state_q == S_SEND) ? DATA_W'(sum_rnd >> FILT_LOG2) : '0;
`else
    assign s_if.out_data = (state_q == S_SEND) ? DATA_W'(sum_q >> FILT_LOG2) : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_smooth_filter_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_smooth_filter_stream
// Description : Directed self-checking bench for smooth_filter_stream with
//               DATA_W=8, MAX_LEN=16, FILT_LOG2=2 (window of 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smooth_filter_stream;
    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             busy, done, err;

    int tests = 0;
    int fails = 0;

    logic [7:0] samp [16];
    logic [7:0] expv [16];

    smooth_filter_stream_if #(.DATA_W(8)) s_if ();

    smooth_filter_stream #(
        .DATA_W   (8),
        .MAX_LEN  (16),
        .FILT_LOG2(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cfg_len(cfg_len),
        .start  (start),
        .abort  (abort),
        .s_if   (s_if.slave),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        cfg_len = LEN_W'(len);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            s_if.in_valid = 1'b1;
            s_if.in_data  = samp[i];
            @(negedge clk);
        end
        s_if.in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int c = 0;
        while (!s_if.out_valid && c < 30) begin
            @(negedge clk);
            c++;
        end
    endtask

    // Collects n outputs; stalls out_ready for 5 cycles at output stall_idx.
    task automatic collect(input int n, input int stall_idx, input string tag);
        for (int j = 0; j < n; j++) begin
            wait_valid();
            chk({tag, "_valid"}, 32'(s_if.out_valid), 32'd1);
            chk({tag, "_data"}, 32'(s_if.out_data), 32'(expv[j]));
            if (j == stall_idx) begin
                s_if.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk({tag, "_stall_valid"}, 32'(s_if.out_valid), 32'd1);
                    chk({tag, "_stall_data"}, 32'(s_if.out_data), 32'(expv[j]));
                end
            end
            s_if.out_ready = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_valid_after"}, 32'(s_if.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 6; i++) samp[i] = 8'(4 * (i + 1));
        expv[0] = 8'd10; expv[1] = 8'd14; expv[2] = 8'd18;
    endtask

    initial begin
        s_if.in_valid  = 1'b0;
        s_if.in_data   = '0;
        s_if.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(s_if.in_ready), 32'd0);
        chk("rst_out_valid", 32'(s_if.out_valid), 32'd0);
        chk("rst_out_data", 32'(s_if.out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;

        // 1. Nominal block
        set_ramp();
        do_start(6);
        chk("s1_busy", 32'(busy), 32'd1);
        chk("s1_in_ready", 32'(s_if.in_ready), 32'd1);
        load(6);
        chk("s1_in_ready_drop", 32'(s_if.in_ready), 32'd0);
        collect(3, -1, "s1");

        // 2. Max values
        for (int i = 0; i < 4; i++) samp[i] = 8'd255;
        expv[0] = 8'd255;
        do_start(4);
        load(4);
        collect(1, -1, "s2");

        // 3. Backpressure at second output
        set_ramp();
        do_start(6);
        load(6);
        collect(3, 1, "s3");

        // 4. Length check
        @(negedge clk);
        cfg_len = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("s4_err_short", 32'(err), 32'd1);
        chk("s4_busy_short", 32'(busy), 32'd0);
        @(negedge clk);
        chk("s4_err_pulse", 32'(err), 32'd0);
        cfg_len = 5'd17; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("s4_err_long", 32'(err), 32'd1);
        chk("s4_busy_long", 32'(busy), 32'd0);

        // 4. Rounding: (1+2+2+2)=7 -> 7/4
        samp[0] = 8'd1; samp[1] = 8'd2; samp[2] = 8'd2; samp[3] = 8'd2;
`ifdef SMOOTH_ROUND_EN
        expv[0] = 8'd2;
`else
        expv[0] = 8'd1;
`endif
        do_start(4);
        chk("s4_err_ok", 32'(err), 32'd0);
        load(4);
        collect(1, -1, "s4");

        // 5. Abort during LOAD
        set_ramp();
        do_start(6);
        load(3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_in_ready", 32'(s_if.in_ready), 32'd0);
        chk("s5_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("s5_done_later", 32'(done), 32'd0);
        do_start(6);
        load(6);
        collect(3, -1, "s5");

        // 6. Reset during SEND
        set_ramp();
        do_start(6);
        load(6);
        s_if.out_ready = 1'b0;
        wait_valid();
        chk("s6_first", 32'(s_if.out_data), 32'd10);
        #2 rst = 1'b0;
        #1;
        chk("s6_rst_valid", 32'(s_if.out_valid), 32'd0);
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_in_ready", 32'(s_if.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        s_if.out_ready = 1'b1;
        @(negedge clk);
        chk("s6_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) samp[i] = 8'd255;
        expv[0] = 8'd255;
        do_start(4);
        chk("s6_restart_busy", 32'(busy), 32'd1);
        load(4);
        collect(1, -1, "s6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/smooth_filter_stream.md
Name: smooth_filter_stream

Overview:
- Parametrised successor to the UART-fed smoothing controller.
- Accepts a runtime-length block of samples over a valid/ready input stream, usually driven by UART_RX, and stores them in an internal buffer.
- Emits the moving average of a power-of-two window over a valid/ready output stream toward UART_TX.
- Replaces the fixed-length RAM/SF handshake with generic width, depth and window, length checking, backpressure and abort.

Parameters:
- DATA_W, 8: sample width in bits.
- MAX_LEN, 100: buffer depth, i.e. the largest accepted block length.
- FILT_LOG2, 3: window WIN = 2**FILT_LOG2 samples; must satisfy WIN <= MAX_LEN.
- Localparam LEN_W = $clog2(MAX_LEN+1).
- Localparam SUM_W = DATA_W+FILT_LOG2.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: reset, asynchronous and active-low.
- cfg_len, input, LEN_W: block length, sampled only when start is accepted.
- start, input, 1: begin a block; honoured only in IDLE.
- abort, input, 1: cancel the current block.
- in_valid, input, 1: input sample valid.
- in_data, input, DATA_W: input sample.
- in_ready, output, 1: block can accept a sample.
- out_valid, output, 1: filtered sample valid.
- out_data, output, DATA_W: filtered sample.
- out_ready, input, 1: downstream accepts the sample.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse after the last output handshake.
- err, output, 1: one-cycle pulse when start is rejected.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all counters and sum = 0.
  - in_ready, out_valid, busy, done, err = 0; out_data = 0.
  - Buffer contents are not reset.
- Handshake: a transfer occurs on a posedge when valid and ready are both high. out_data and out_valid stay stable until out_ready.
- IDLE:
  - On start with WIN <= cfg_len <= MAX_LEN: latch len, clear wr_ptr, go to LOAD.
  - On start with an out-of-range cfg_len: pulse err and stay in IDLE.
- LOAD:
  - in_ready=1. Each input handshake writes buf[wr_ptr] and increments wr_ptr.
  - The handshake with wr_ptr==len-1 moves to PRIME; in_ready drops the next cycle.
  - Extra in_valid after that is ignored (not acknowledged).
- PRIME:
  - Adds buf[0..WIN-1] into sum, one per cycle (WIN cycles), then k=0 and go to SEND.
  - sum is SUM_W bits and cannot overflow.
- SEND:
  - out_valid=1, out_data = sum >> FILT_LOG2, i.e. the average of buf[k..k+WIN-1].
  - On handshake, if k == len-WIN: go to IDLE and pulse done next cycle.
  - Otherwise: sum <= sum + buf[k+WIN] - buf[k]; k <= k+1.
  - The next out_data is valid the cycle after the handshake, giving at most 1 output per cycle.
  - Output count = len-WIN+1.
  - len==WIN gives exactly one output.
- Buffer is a register array with combinational read.
- abort in any non-IDLE state:
  - Next state is IDLE; in_ready and out_valid drop the next cycle.
  - No done pulse; counters cleared.
  - abort has priority over a simultaneous handshake; that handshake is not counted.
- start while busy is ignored, and err is not pulsed.
- Reset mid-operation behaves as abort, except that all outputs go low immediately (asynchronous).

Optional Feature:
- Macro: SMOOTH_ROUND_EN.
- With the macro defined: out_data = (sum + 2**(FILT_LOG2-1)) >> FILT_LOG2, rounding half up. The intermediate is SUM_W+1 bits, so the result fits DATA_W.
- Without it: truncation, out_data = sum >> FILT_LOG2.
- Latency is identical in both builds.

Test Plan (all scenarios use DATA_W=8, MAX_LEN=16, FILT_LOG2=2, WIN=4):
- 1. Nominal block. start, cfg_len=6, in_data 4,8,12,16,20,24 with out_ready=1 -> out_data 10,14,18, then done pulse; busy low the cycle after done.
- 2. Max values. cfg_len=4, samples 255,255,255,255 -> one output 255; no overflow; done pulse.
- 3. Backpressure. Scenario 1 with out_ready held low for 5 cycles at the second output -> out_valid stays high and out_data holds 14 throughout; the sequence is still 10,14,18.
- 4. Length check and rounding.
  - cfg_len=3 -> err pulse, busy stays 0. cfg_len=17 -> err pulse.
  - cfg_len=4, samples 1,2,2,2 -> output 1 without SMOOTH_ROUND_EN, 2 with it.
- 5. Abort during LOAD. Abort after 3 of 6 samples -> IDLE next cycle, in_ready=0, no done. A subsequent scenario-1 block produces 10,14,18.
- 6. Reset during SEND. rst low after the first output -> out_valid, busy and in_ready are 0 immediately. After release, the block returns to IDLE and accepts a new start.
